// File: rtl/mips_multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module : mips_multicycle_control_if
// Brief  : Bundle of the signals exchanged between the multicycle control FSM
//          and the datapath. Instruction fields and the ALU zero flag flow
//          into the controller; mux selects and write strobes flow out.
//          master = controller side, slave = datapath side.
// Rev    : 1.0  initial release
// ============================================================================
interface mips_multicycle_control_if;
  logic [5:0] Op;          // Instr[31:26] from the instruction register
  logic [5:0] Funct;       // Instr[5:0]
  logic       ZeroFlag;    // ALU zero flag
  logic [2:0] ALUControl;  // 000 AND, 001 OR, 010 add, 100 sub, 101 mul, 110 slt
  logic       ALUSrcA;     // 0 = PC, 1 = register A
  logic [1:0] ALUSrcB;     // 00 = B, 01 = 4, 10 = signext imm, 11 = imm<<2
  logic       IorD;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       PCEn;
  logic [1:0] PCSrc;       // 00 = ALUResult, 01 = ALUOut, 10 = jump target

  modport master (
    input  Op, Funct, ZeroFlag,
    output ALUControl, ALUSrcA, ALUSrcB, IorD, IRWrite, MemWrite,
           RegWrite, RegDst, MemtoReg, PCEn, PCSrc
  );

  modport slave (
    output Op, Funct, ZeroFlag,
    input  ALUControl, ALUSrcA, ALUSrcB, IorD, IRWrite, MemWrite,
           RegWrite, RegDst, MemtoReg, PCEn, PCSrc
  );
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module : mips_multicycle_control
// Brief  : Moore-style control FSM for a multicycle MIPS datapath supporting
//          lw, sw, R-type (add/sub/and/or/slt/mul), addi, beq and j.
// Ports  : CLK   - clock, rising edge
//          RST   - asynchronous active-low reset (forces FETCH immediately)
//          bus   - master modport: Op/Funct/ZeroFlag in, datapath controls out
//          State - current state encoding (debug)
// Rev    : 1.0  initial release
// ============================================================================
module mips_multicycle_control #(
  parameter int STATE_W = 4
) (
  input  wire                          CLK,
  input  wire                          RST,
  mips_multicycle_control_if.master    bus,
  output logic [STATE_W-1:0]           State
);

  typedef enum logic [STATE_W-1:0] {
    FETCH  = STATE_W'(0),
    DECODE = STATE_W'(1),
    MEMADR = STATE_W'(2),
    MEMRD  = STATE_W'(3),
    MEMWB  = STATE_W'(4),
    MEMWR  = STATE_W'(5),
    EXEC   = STATE_W'(6),
    ALUWB  = STATE_W'(7),
    BRANCH = STATE_W'(8),
    ADDIEX = STATE_W'(9),
    ADDIWB = STATE_W'(10),
    JUMP   = STATE_W'(11)
  } state_t;

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_j     = 6'b000010;

  state_t r_state;
  state_t w_next;
  logic   w_pcwrite;
  logic   w_branch;

  // State register: reset forces FETCH without waiting for an edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= FETCH;
    else      r_state <= w_next;
  end

  // Next-state and output decode. Outputs depend on r_state only (plus Funct
  // in EXEC, which comes from the held instruction register).
  always_comb begin
    w_next         = FETCH;
    w_pcwrite      = 1'b0;
    w_branch       = 1'b0;
    bus.ALUControl = 3'b010;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.IorD       = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.RegDst     = 1'b0;
    bus.MemtoReg   = 1'b0;
    bus.PCSrc      = 2'b00;

    case (r_state)
      FETCH: begin
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = 1'b1;
        w_pcwrite   = 1'b1;
        w_next      = DECODE;
      end
      DECODE: begin
        bus.ALUSrcB = 2'b11;  // precompute branch target into ALUOut
        case (bus.Op)
          c_op_lw, c_op_sw: w_next = MEMADR;
          c_op_rtype:       w_next = EXEC;
          c_op_beq:         w_next = BRANCH;
          c_op_addi:        w_next = ADDIEX;
          c_op_j:           w_next = JUMP;
          default:          w_next = FETCH;
        endcase
      end
      MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        w_next      = (bus.Op == c_op_lw) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.IorD = 1'b1;
        w_next   = MEMWB;
      end
      MEMWB: begin
        bus.MemtoReg = 1'b1;
        bus.RegWrite = 1'b1;
        w_next       = FETCH;
      end
      MEMWR: begin
        bus.IorD     = 1'b1;
        bus.MemWrite = 1'b1;
        w_next       = FETCH;
      end
      EXEC: begin
        bus.ALUSrcA = 1'b1;
        case (bus.Funct)
          6'b100000: bus.ALUControl = 3'b010;
          6'b100010: bus.ALUControl = 3'b100;
          6'b100100: bus.ALUControl = 3'b000;
          6'b100101: bus.ALUControl = 3'b001;
          6'b101010: bus.ALUControl = 3'b110;
          6'b011000: bus.ALUControl = 3'b101;
          default:   bus.ALUControl = 3'b010;
        endcase
        w_next = ALUWB;
      end
      ALUWB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
        w_next       = FETCH;
      end
      BRANCH: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUControl = 3'b100;
        bus.PCSrc      = 2'b01;
        w_branch       = 1'b1;
        w_next         = FETCH;
      end
      ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        w_next      = ADDIWB;
      end
      ADDIWB: begin
        bus.RegWrite = 1'b1;
        w_next       = FETCH;
      end
      JUMP: begin
        bus.PCSrc = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = FETCH;
      end
      // Unused encodings keep the defaults and recover to FETCH.
      default: w_next = FETCH;
    endcase
  end

  // Branch resolution uses the live zero flag of the subtract in BRANCH,
  // so PCEn is the one output that is not a pure state decode.
  assign bus.PCEn = w_pcwrite | (w_branch & bus.ZeroFlag);
  assign State    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module : tb_mips_multicycle_control
// Brief  : Directed-vector bench for mips_multicycle_control. Each cycle the
//          stimulus drives Op/Funct/ZeroFlag/RST and queues the hand-computed
//          expected outputs; an independent monitor pops and compares.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mips_multicycle_control;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [3:0] State;

  mips_multicycle_control_if bus();

  mips_multicycle_control #(.STATE_W(4)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .bus   (bus),
    .State (State)
  );

  always #5 CLK = ~CLK;

  // Packed layout: state, alu, srca, srcb, iord, irw, memw, regw, regdst,
  // memtoreg, pcen, pcsrc
  typedef struct {
    string       tag;
    logic [18:0] v;
  } item_t;

  item_t q[$];
  int    errors = 0;
  int    checks = 0;
  event  chk_ev;

  function automatic logic [18:0] v(input logic [3:0] st, input logic [2:0] alu,
                                    input logic sa, input logic [1:0] sb,
                                    input logic iord, input logic irw,
                                    input logic mw, input logic rw,
                                    input logic rd, input logic m2r,
                                    input logic pcen, input logic [1:0] pcs);
    return {st, alu, sa, sb, iord, irw, mw, rw, rd, m2r, pcen, pcs};
  endfunction

  // Hand-computed expected output vectors per state
  logic [18:0] F, D, MA, MRD, MWB, MWR, AWB, BR1, BR0, AEX, AIWB, J;
  logic [18:0] EX_SLT, EX_SUB, EX_AND, EX_MUL, EX_OR;

  // Monitor: compares on every falling edge, or immediately on chk_ev.
  initial begin
    item_t       it;
    logic [18:0] act;
    forever begin
      @(negedge CLK or chk_ev);
      if (q.size() > 0) begin
        it  = q.pop_front();
        act = {State, bus.ALUControl, bus.ALUSrcA, bus.ALUSrcB, bus.IorD,
               bus.IRWrite, bus.MemWrite, bus.RegWrite, bus.RegDst,
               bus.MemtoReg, bus.PCEn, bus.PCSrc};
        checks++;
        if (act !== it.v) begin
          errors++;
          $display("FAIL %s: actual=%05h required=%05h (state %0d vs %0d)",
                   it.tag, act, it.v, act[18:15], it.v[18:15]);
        end
      end
    end
  end

  task automatic step(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                      input logic zf, input logic [18:0] e, input string tag);
    @(posedge CLK);
    #1;
    RST          = rst;
    bus.Op       = op;
    bus.Funct    = fn;
    bus.ZeroFlag = zf;
    q.push_back('{tag, e});
  endtask

  initial begin
    bus.Op = 6'd0; bus.Funct = 6'd0; bus.ZeroFlag = 1'b0;

    F      = v(4'd0,  3'b010, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    D      = v(4'd1,  3'b010, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    MA     = v(4'd2,  3'b010, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    MRD    = v(4'd3,  3'b010, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    MWB    = v(4'd4,  3'b010, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
    MWR    = v(4'd5,  3'b010, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    EX_SLT = v(4'd6,  3'b110, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    EX_SUB = v(4'd6,  3'b100, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    EX_AND = v(4'd6,  3'b000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    EX_MUL = v(4'd6,  3'b101, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    EX_OR  = v(4'd6,  3'b001, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    AWB    = v(4'd7,  3'b010, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
    BR1    = v(4'd8,  3'b100, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    BR0    = v(4'd8,  3'b100, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
    AEX    = v(4'd9,  3'b010, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    AIWB   = v(4'd10, 3'b010, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    J      = v(4'd11, 3'b010, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10);

    // Held in reset across edges: stays in FETCH with FETCH outputs.
    step(1'b0, 6'b100011, 6'd0, 1'b0, F, "reset_hold0");
    step(1'b0, 6'b100011, 6'd0, 1'b0, F, "reset_hold1");

    // lw: 0,1,2,3,4. Op changes in FETCH/MEMRD/MEMWB must be ignored.
    step(1'b1, 6'b111111, 6'd0, 1'b0, F,   "lw_fetch");
    step(1'b1, 6'b100011, 6'd0, 1'b0, D,   "lw_decode");
    step(1'b1, 6'b100011, 6'd0, 1'b0, MA,  "lw_memadr");
    step(1'b1, 6'b000000, 6'd0, 1'b0, MRD, "lw_memrd");
    step(1'b1, 6'b111111, 6'd0, 1'b0, MWB, "lw_memwb");

    // sw: 0,1,2,5
    step(1'b1, 6'b101011, 6'd0, 1'b0, F,   "sw_fetch");
    step(1'b1, 6'b101011, 6'd0, 1'b0, D,   "sw_decode");
    step(1'b1, 6'b101011, 6'd0, 1'b0, MA,  "sw_memadr");
    step(1'b1, 6'b100011, 6'd0, 1'b0, MWR, "sw_memwr");

    // R-type slt: 0,1,6,7
    step(1'b1, 6'b000000, 6'b101010, 1'b0, F,      "slt_fetch");
    step(1'b1, 6'b000000, 6'b101010, 1'b0, D,      "slt_decode");
    step(1'b1, 6'b000000, 6'b101010, 1'b0, EX_SLT, "slt_exec");
    step(1'b1, 6'b000000, 6'b100010, 1'b0, AWB,    "slt_aluwb");

    // R-type sub, then mul, or
    step(1'b1, 6'b000000, 6'b100010, 1'b0, F,      "sub_fetch");
    step(1'b1, 6'b000000, 6'b100010, 1'b0, D,      "sub_decode");
    step(1'b1, 6'b000000, 6'b100010, 1'b0, EX_SUB, "sub_exec");
    step(1'b1, 6'b000000, 6'b011000, 1'b0, AWB,    "sub_aluwb");
    step(1'b1, 6'b000000, 6'b011000, 1'b0, F,      "mul_fetch");
    step(1'b1, 6'b000000, 6'b011000, 1'b0, D,      "mul_decode");
    step(1'b1, 6'b000000, 6'b011000, 1'b0, EX_MUL, "mul_exec");
    step(1'b1, 6'b000000, 6'b100101, 1'b0, AWB,    "mul_aluwb");
    step(1'b1, 6'b000000, 6'b100101, 1'b0, F,      "or_fetch");
    step(1'b1, 6'b000000, 6'b100101, 1'b0, D,      "or_decode");
    step(1'b1, 6'b000000, 6'b100101, 1'b0, EX_OR,  "or_exec");
    step(1'b1, 6'b000000, 6'b100101, 1'b0, AWB,    "or_aluwb");

    // addi: 0,1,9,10
    step(1'b1, 6'b001000, 6'd0, 1'b0, F,    "addi_fetch");
    step(1'b1, 6'b001000, 6'd0, 1'b0, D,    "addi_decode");
    step(1'b1, 6'b001000, 6'd0, 1'b0, AEX,  "addi_exec");
    step(1'b1, 6'b001000, 6'd0, 1'b0, AIWB, "addi_wb");

    // beq taken then not taken
    step(1'b1, 6'b000100, 6'd0, 1'b0, F,   "beq1_fetch");
    step(1'b1, 6'b000100, 6'd0, 1'b0, D,   "beq1_decode");
    step(1'b1, 6'b000100, 6'd0, 1'b1, BR1, "beq1_branch_zf1");
    step(1'b1, 6'b000100, 6'd0, 1'b1, F,   "beq0_fetch");
    step(1'b1, 6'b000100, 6'd0, 1'b1, D,   "beq0_decode");
    step(1'b1, 6'b000100, 6'd0, 1'b0, BR0, "beq0_branch_zf0");

    // unknown opcode returns from DECODE; then j
    step(1'b1, 6'b111111, 6'd0, 1'b0, F, "unk_fetch");
    step(1'b1, 6'b111111, 6'd0, 1'b0, D, "unk_decode");
    step(1'b1, 6'b000010, 6'd0, 1'b0, F, "j_fetch");
    step(1'b1, 6'b000010, 6'd0, 1'b0, D, "j_decode");
    step(1'b1, 6'b000010, 6'd0, 1'b0, J, "j_jump");

    // R-type and, aborted by reset mid-cycle in ALUWB
    step(1'b1, 6'b000000, 6'b100100, 1'b0, F,      "and_fetch");
    step(1'b1, 6'b000000, 6'b100100, 1'b0, D,      "and_decode");
    step(1'b1, 6'b000000, 6'b100100, 1'b0, EX_AND, "and_exec");
    step(1'b1, 6'b000000, 6'b100100, 1'b0, AWB,    "and_aluwb");
    @(negedge CLK);
    #2;
    RST = 1'b0;
    q.push_back('{"async_reset_in_aluwb", F});
    #1;
    -> chk_ev;

    step(1'b0, 6'b000000, 6'd0, 1'b0, F, "reset_hold2");
    step(1'b1, 6'b000000, 6'd0, 1'b0, F, "rel_fetch");
    step(1'b1, 6'b000000, 6'd0, 1'b0, D, "rel_decode");

    // Drain with a bounded wait.
    begin
      int n = 0;
      while (q.size() > 0 && n < 10) begin
        @(posedge CLK);
        n++;
      end
      if (q.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL drain: actual=%0d pending required=0", q.size());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
